// File: rtl/fft16_pkg.sv
// fft16_pkg
//   Shared definitions for the 16-point FFT sequencer: controller state
//   encoding, transform geometry constants and the 4-bit bit-reversal helper
//   used to place input samples for in-place decimation-in-time.
package fft16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_UNLOAD
    } state_e;

    localparam int unsigned STAGES       = 4;
    localparam int unsigned BF_PER_STAGE = 8;
    localparam int unsigned POINTS       = 16;

    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage

// File: rtl/fft16_twiddle_rom.sv
// fft16_twiddle_rom
//   Combinational twiddle table: k -> W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16)
//   in signed Q-format. Entries are stored at Q=8 and rescaled for other Q.
// Ports:
//   k_i      in  3  twiddle index 0..7
//   tw_re_o  out N  real part
//   tw_im_o  out N  imaginary part
module fft16_twiddle_rom #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic [2:0]   k_i,
    output logic [N-1:0] tw_re_o,
    output logic [N-1:0] tw_im_o
);

    function automatic logic [N-1:0] sc(input int v);
        int t;
        t = (v * (2 ** Q)) / 256;
        return N'(t);
    endfunction

    always_comb begin
        tw_re_o = '0;
        tw_im_o = '0;
        case (k_i)
            3'd0: begin tw_re_o = sc(256);  tw_im_o = sc(0);    end
            3'd1: begin tw_re_o = sc(237);  tw_im_o = sc(-98);  end
            3'd2: begin tw_re_o = sc(181);  tw_im_o = sc(-181); end
            3'd3: begin tw_re_o = sc(98);   tw_im_o = sc(-237); end
            3'd4: begin tw_re_o = sc(0);    tw_im_o = sc(-256); end
            3'd5: begin tw_re_o = sc(-98);  tw_im_o = sc(-237); end
            3'd6: begin tw_re_o = sc(-181); tw_im_o = sc(-181); end
            3'd7: begin tw_re_o = sc(-237); tw_im_o = sc(-98);  end
            default: begin tw_re_o = '0;    tw_im_o = '0;       end
        endcase
    end

endmodule

// File: rtl/fft16_sequencer.sv
// fft16_sequencer
//   Loads 16 complex samples in bit-reversed order, drives one external
//   butterfly through 4 stages x 8 butterflies with in-place write-back, then
//   streams the 16 bins out in natural order.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_start                 start pulse, honoured in IDLE only
//   i_valid/o_ready, i_data_re/im           sample input stream
//   o_bf_in0/in1_re/im, o_bf_twiddle_re/im  butterfly operands (held through WAIT)
//   i_bf_out0/out1_re/im, i_bf_done         butterfly results and completion
//   o_valid/i_ready, o_data_re/im, o_index  spectrum output stream
//   o_busy                  high outside IDLE
//   o_done                  one-cycle pulse after the last bin is accepted
module fft16_sequencer
    import fft16_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_valid,
    input  logic [N-1:0] i_data_re,
    input  logic [N-1:0] i_data_im,
    output logic         o_ready,
    output logic [N-1:0] o_bf_in0_re,
    output logic [N-1:0] o_bf_in0_im,
    output logic [N-1:0] o_bf_in1_re,
    output logic [N-1:0] o_bf_in1_im,
    output logic [N-1:0] o_bf_twiddle_re,
    output logic [N-1:0] o_bf_twiddle_im,
    input  logic [N-1:0] i_bf_out0_re,
    input  logic [N-1:0] i_bf_out0_im,
    input  logic [N-1:0] i_bf_out1_re,
    input  logic [N-1:0] i_bf_out1_im,
    input  logic         i_bf_done,
    output logic         o_valid,
    output logic [N-1:0] o_data_re,
    output logic [N-1:0] o_data_im,
    output logic [3:0]   o_index,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_done
);

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [1:0]   stage_q;
    logic [2:0]   bf_q;
    logic         bf_done_q;
    logic         ready_q, valid_q, busy_q, done_q;
    logic [N-1:0] in0_re_q, in0_im_q, in1_re_q, in1_im_q, tw_re_q, tw_im_q;

    logic [N-1:0] ram_re [POINTS];
    logic [N-1:0] ram_im [POINTS];

    logic [3:0]   span, top_addr, bot_addr;
    logic [2:0]   stage_p1, tw_k;
    logic [N-1:0] tw_re, tw_im;
    logic         load_we, bf_rise;

    // Butterfly addressing: b splits into group (b>>s) and offset within group.
    always_comb begin
        span     = 4'd1 << stage_q;
        stage_p1 = {1'b0, stage_q} + 3'd1;
        top_addr = (({1'b0, bf_q} >> stage_q) << stage_p1) | ({1'b0, bf_q} & (span - 4'd1));
        bot_addr = top_addr + span;
        tw_k     = 3'(({1'b0, bf_q} & (span - 4'd1)) << (2'd3 - stage_q));
    end

    fft16_twiddle_rom #(.N(N), .Q(Q)) u_twiddle_rom (
        .k_i     (tw_k),
        .tw_re_o (tw_re),
        .tw_im_o (tw_im)
    );

    assign load_we = (state_q == ST_LOAD) && i_valid;
    // Only a low-to-high transition seen against the registered copy counts,
    // so a level still high from ISSUE (or an earlier butterfly) is ignored.
    assign bf_rise = i_bf_done && !bf_done_q;

    always_ff @(posedge i_clk) begin
        if (load_we) begin
            ram_re[bitrev4(cnt_q)] <= i_data_re;
            ram_im[bitrev4(cnt_q)] <= i_data_im;
        end
        if (state_q == ST_WRITE) begin
            ram_re[top_addr] <= i_bf_out0_re;
            ram_im[top_addr] <= i_bf_out0_im;
            ram_re[bot_addr] <= i_bf_out1_re;
            ram_im[bot_addr] <= i_bf_out1_im;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stage_q   <= '0;
            bf_q      <= '0;
            bf_done_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            in0_re_q  <= '0;
            in0_im_q  <= '0;
            in1_re_q  <= '0;
            in1_im_q  <= '0;
            tw_re_q   <= '0;
            tw_im_q   <= '0;
        end else begin
            bf_done_q <= i_bf_done;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (i_valid) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= ST_ISSUE;
                            ready_q <= 1'b0;
                            stage_q <= '0;
                            bf_q    <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    in0_re_q <= ram_re[top_addr];
                    in0_im_q <= ram_im[top_addr];
                    in1_re_q <= ram_re[bot_addr];
                    in1_im_q <= ram_im[bot_addr];
                    tw_re_q  <= tw_re;
                    tw_im_q  <= tw_im;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bf_rise) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    bf_q <= bf_q + 3'd1;
                    if (bf_q == 3'd7) stage_q <= stage_q + 2'd1;
                    if (stage_q == 2'd3 && bf_q == 3'd7) begin
                        state_q <= ST_UNLOAD;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_UNLOAD: begin
                    if (i_ready) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready         = ready_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_valid         = valid_q;
    assign o_bf_in0_re     = in0_re_q;
    assign o_bf_in0_im     = in0_im_q;
    assign o_bf_in1_re     = in1_re_q;
    assign o_bf_in1_im     = in1_im_q;
    assign o_bf_twiddle_re = tw_re_q;
    assign o_bf_twiddle_im = tw_im_q;
    // Output bin is read straight from the array; gated so it idles at zero.
    assign o_index         = valid_q ? cnt_q : '0;
    assign o_data_re       = valid_q ? ram_re[cnt_q] : '0;
    assign o_data_im       = valid_q ? ram_im[cnt_q] : '0;

endmodule

// File: doc/fft16_sequencer.md
# fft16_sequencer

Control and data-memory block that drives one `butterfly2` instance through a full 16-point radix-2 DIT FFT. It accepts 16 complex samples on a valid/ready stream and stores them in bit-reversed order. It then issues 4 stages × 8 butterflies to the butterfly's operand ports, waits for each butterfly-done pulse, and writes the results back in place. Finally it streams the 16 spectrum bins out in natural order. It sits between the sample source and the result sink, and is the issuing and write-back end of the butterfly's operand/result interface.

## Interface
Parameters:
- `N`, 16, word width of each real/imag component (signed, two's complement).
- `Q`, 8, fractional bits; used only by the twiddle ROM.

Ports:
- `i_clk` in 1, single clock, rising edge.
- `i_rst` in 1, asynchronous, active-low reset.
- `i_start` in 1, one-cycle pulse that starts a transform; honoured only in IDLE.
- `i_valid` in 1, input sample valid.
- `i_data_re`, `i_data_im` in N, input sample.
- `o_ready` out 1, high only in LOAD.
- `o_bf_in0_re`, `o_bf_in0_im`, `o_bf_in1_re`, `o_bf_in1_im` out N, butterfly operands (top, bottom).
- `o_bf_twiddle_re`, `o_bf_twiddle_im` out N, W16^k in Q-format.
- `i_bf_out0_re`, `i_bf_out0_im`, `i_bf_out1_re`, `i_bf_out1_im` in N, butterfly results.
- `i_bf_done` in 1, butterfly completion, may stay high for more than one cycle.
- `o_valid` out 1, output bin valid.
- `o_data_re`, `o_data_im` out N, output bin.
- `o_index` out 4, bin number of the current output.
- `i_ready` in 1, sink ready.
- `o_busy` out 1, high in every state except IDLE.
- `o_done` out 1, one-cycle pulse after the last bin is accepted.

## Operation
- **States:** IDLE, LOAD, ISSUE, WAIT, WRITE, UNLOAD.
- **IDLE → LOAD** on `i_start`. `i_start` is ignored in every other state.
- **LOAD**
  - Each beat with `i_valid && o_ready` writes sample n (n counts 0..15) to RAM address bitrev4(n).
  - After beat 15, go to ISSUE with stage s=0 and butterfly b=0.
- **Addressing** for stage s and butterfly b:
  - span = 1<<s
  - top = ((b>>s)<<(s+1)) | (b & (span-1))
  - bot = top + span
  - twiddle index k = (b & (span-1)) << (3-s)
- **ISSUE** registers RAM[top], RAM[bot] and the twiddle into the operand outputs, then goes to WAIT.
- **WAIT**
  - Operand outputs stay stable for the whole state.
  - Leaves on a rising edge of `i_bf_done`, detected against a registered copy. A level that is already high on entry does not count.
- **WRITE**
  - RAM[top] ← out0 and RAM[bot] ← out1.
  - Increment b. When b wraps from 7 to 0, increment s.
  - After s=3, b=7, go to UNLOAD; otherwise go back to ISSUE.
- **UNLOAD**
  - Presents RAM[i] with `o_index`=i for i=0..15.
  - Advances i only on `o_valid && i_ready`. Data is held while `i_ready` is low.
  - After bin 15 is accepted, pulse `o_done` and go to IDLE.
- **Arithmetic:** no scaling and no saturation in the sequencer; results are stored as received. Callers pre-scale inputs so that the stage gain of 16× does not overflow.

## Timing
- **Reset:** asserting `i_rst` low at any time, including mid-WAIT or mid-UNLOAD, forces IDLE. All outputs go to 0 and the counters clear. RAM contents are don't-care.
- **Latency**
  - LOAD takes 16 accepted beats.
  - Each butterfly costs 1 (ISSUE) + W (WAIT) + 1 (WRITE) cycles, where W is the number of cycles until the `i_bf_done` rising edge.
  - UNLOAD takes at least 16 cycles.
  - `o_done` rises in the cycle after the bin-15 handshake.
- **Boundaries**
  - If `i_bf_done` rises in the ISSUE cycle, it is ignored; WAIT requires a fresh rising edge.
  - `i_valid` outside LOAD is ignored.
  - `i_ready` outside UNLOAD is ignored.

## Structure
- **Shared package `fft16_pkg`:** state encoding, `STAGES`=4, `BF_PER_STAGE`=8, `POINTS`=16, and the bitrev4 function.
- **Sub-module `fft16_twiddle_rom`:** combinational, k[2:0] → W16^k. For Q=8 the values are:
  - k0 = (256, 0)
  - k1 = (237, −98)
  - k2 = (181, −181)
  - k3 = (98, −237)
  - k4 = (0, −256)
  - k5 = (−98, −237)
  - k6 = (−181, −181)
  - k7 = (−237, −98)
- **Sample RAM:** a 16×2N register array inside the sequencer.

## Test plan
- **Impulse:** x[0]=(256,0), others 0, with a behavioural butterfly model that asserts done after 5 cycles → all 16 bins equal (256,0), and `o_index` runs 0..15.
- **DC:** all samples (16,0) → bin 0 = (256,0), bins 1..15 = (0,0).
- **Addressing probe:**
  - Stage 0, b=0 issues RAM[0]/RAM[1] with twiddle (256,0).
  - Stage 3, b=1 issues RAM[1]/RAM[9] with twiddle (237,−98).
- **Done handling:** hold `i_bf_done` high for 3 cycles on every butterfly → exactly 32 WRITE cycles in the transform.
- **Backpressure:** toggle `i_ready` 1-0-0-1 during UNLOAD → no bin dropped or duplicated, data stable while stalled, and `o_done` fires once.
- **Reset and restart:**
  - Assert `i_rst` low during stage 2 WAIT → all outputs 0 and IDLE next cycle.
  - `i_start` pulsed during LOAD → ignored, no restart.
